exec_ctrl_queue: RTL and testbench

EXEC_CTRL_QUEUE -- requirements
Module: mor1kx_exec_ctrl_queue

---
 rtl/exec_ctrl_queue.sv | 167 ++++++++++++++++
 tb/tb_exec_ctrl_queue.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/exec_ctrl_queue.sv
// Execute-to-control queue: a FIFO of retired execute results with late
// exception merging at the head and a single writeback stage register.
module exec_ctrl_queue #(
  parameter int OPTION_OPERAND_WIDTH = 32,
  parameter int OPTION_RF_ADDR_WIDTH = 5,
  parameter logic [31:0] OPTION_RESET_PC = 32'h00000100,
  parameter int NUM_EXCEPT           = 11,
  parameter int DEPTH                = 2
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               exe_valid_i,
  output logic                               exe_ready_o,
  input  logic [OPTION_OPERAND_WIDTH-1:0]    exe_pc_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0]    exe_result_i,
  input  logic [OPTION_RF_ADDR_WIDTH-1:0]    exe_rfd_adr_i,
  input  logic                               exe_rf_wb_i,
  input  logic [NUM_EXCEPT-1:0]              exe_except_i,
  input  logic                               exe_bubble_i,
  input  logic [NUM_EXCEPT-1:0]              lsu_except_i,
  input  logic                               pipeline_flush_i,
  input  logic                               du_stall_i,
  output logic                               ctrl_valid_o,
  input  logic                               ctrl_ready_i,
  output logic [OPTION_OPERAND_WIDTH-1:0]    ctrl_pc_o,
  output logic [OPTION_OPERAND_WIDTH-1:0]    ctrl_result_o,
  output logic [OPTION_RF_ADDR_WIDTH-1:0]    ctrl_rfd_adr_o,
  output logic                               ctrl_rf_wb_o,
  output logic [NUM_EXCEPT-1:0]              ctrl_except_o,
  output logic                               ctrl_except_any_o,
  output logic                               wb_rf_wb_o,
  output logic [OPTION_RF_ADDR_WIDTH-1:0]    wb_rfd_adr_o,
  output logic [OPTION_OPERAND_WIDTH-1:0]    wb_result_o,
  output logic [$clog2(DEPTH+1)-1:0]         count_o
);

  localparam int W  = OPTION_OPERAND_WIDTH;
  localparam int A  = OPTION_RF_ADDR_WIDTH;
  localparam int E  = NUM_EXCEPT;
  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [W-1:0]  RESET_PC = W'(OPTION_RESET_PC);
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

  logic [W-1:0] pc_mem_q  [DEPTH];
  logic [W-1:0] pc_mem_d  [DEPTH];
  logic [W-1:0] res_mem_q [DEPTH];
  logic [W-1:0] res_mem_d [DEPTH];
  logic [A-1:0] rfd_mem_q [DEPTH];
  logic [A-1:0] rfd_mem_d [DEPTH];
  logic         wb_mem_q  [DEPTH];
  logic         wb_mem_d  [DEPTH];
  logic [E-1:0] ex_mem_q  [DEPTH];
  logic [E-1:0] ex_mem_d  [DEPTH];

  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic          except_block_q, except_block_d;
  logic [W-1:0]  last_pc_q, last_pc_d;
  logic          wb_rf_wb_q, wb_rf_wb_d;
  logic [A-1:0]  wb_rfd_adr_q, wb_rfd_adr_d;
  logic [W-1:0]  wb_result_q, wb_result_d;

  logic flush, empty, push, pop;

  // Handshake and head view; exe_ready_o deliberately ignores ctrl_ready_i.
  always_comb begin
    flush             = pipeline_flush_i & ~du_stall_i;
    empty             = (count_q == '0);
    exe_ready_o       = (count_q != DEPTH_C) & ~except_block_q & ~flush;
    ctrl_valid_o      = ~empty;
    push              = exe_valid_i & exe_ready_o;
    pop               = ctrl_valid_o & ctrl_ready_i;
    ctrl_pc_o         = empty ? last_pc_q : pc_mem_q[rd_ptr_q];
    ctrl_result_o     = res_mem_q[rd_ptr_q];
    ctrl_rfd_adr_o    = rfd_mem_q[rd_ptr_q];
    ctrl_rf_wb_o      = ~empty & wb_mem_q[rd_ptr_q];
    ctrl_except_o     = empty ? '0 : (ex_mem_q[rd_ptr_q] | lsu_except_i);
    ctrl_except_any_o = |ctrl_except_o;
    count_o           = count_q;
    wb_rf_wb_o        = wb_rf_wb_q;
    wb_rfd_adr_o      = wb_rfd_adr_q;
    wb_result_o       = wb_result_q;
  end

  always_comb begin
    pc_mem_d       = pc_mem_q;
    res_mem_d      = res_mem_q;
    rfd_mem_d      = rfd_mem_q;
    wb_mem_d       = wb_mem_q;
    ex_mem_d       = ex_mem_q;
    count_d        = count_q;
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    except_block_d = except_block_q;
    last_pc_d      = last_pc_q;
    wb_rf_wb_d     = 1'b0;
    wb_rfd_adr_d   = wb_rfd_adr_q;
    wb_result_d    = wb_result_q;

    if (flush) begin
      count_d        = '0;
      wr_ptr_d       = '0;
      rd_ptr_d       = '0;
      except_block_d = 1'b0;
    end else begin
      if (push) begin
        pc_mem_d[wr_ptr_q]  = exe_bubble_i ? last_pc_q : exe_pc_i;
        res_mem_d[wr_ptr_q] = exe_result_i;
        rfd_mem_d[wr_ptr_q] = exe_rfd_adr_i;
        wb_mem_d[wr_ptr_q]  = exe_rf_wb_i & ~exe_bubble_i;
        ex_mem_d[wr_ptr_q]  = exe_bubble_i ? '0 : exe_except_i;
        wr_ptr_d            = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
        if (!exe_bubble_i)
          last_pc_d = exe_pc_i;
      end
      // Head slot cannot alias the write slot: push needs room, update needs data.
      if (pop) begin
        rd_ptr_d     = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
        wb_rf_wb_d   = ctrl_rf_wb_o & ~ctrl_except_any_o;
        wb_rfd_adr_d = ctrl_rfd_adr_o;
        wb_result_d  = ctrl_result_o;
      end else if (!empty) begin
        ex_mem_d[rd_ptr_q] = ctrl_except_o;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
      if ((push && (|exe_except_i)) || (!empty && (|lsu_except_i)))
        except_block_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q        <= '0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      except_block_q <= 1'b0;
      last_pc_q      <= RESET_PC;
      wb_rf_wb_q     <= 1'b0;
      wb_rfd_adr_q   <= '0;
      wb_result_q    <= '0;
    end else begin
      count_q        <= count_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      except_block_q <= except_block_d;
      last_pc_q      <= last_pc_d;
      wb_rf_wb_q     <= wb_rf_wb_d;
      wb_rfd_adr_q   <= wb_rfd_adr_d;
      wb_result_q    <= wb_result_d;
    end
  end

  always_ff @(posedge clk) begin
    pc_mem_q  <= pc_mem_d;
    res_mem_q <= res_mem_d;
    rfd_mem_q <= rfd_mem_d;
    wb_mem_q  <= wb_mem_d;
    ex_mem_q  <= ex_mem_d;
  end

endmodule

// File: tb/tb_exec_ctrl_queue.sv
// Randomized bench for exec_ctrl_queue: queue-based reference model compared
// every cycle, plus directed scenarios with literal expectations.
module tb_exec_ctrl_queue;

  localparam int W = 32;
  localparam int A = 5;
  localparam int E = 11;
  localparam int DEPTH = 2;
  localparam logic [31:0] RST_PC = 32'h00000100;

  logic         clk = 1'b0;
  logic         rst;
  logic         exe_valid_i, exe_ready_o;
  logic [W-1:0] exe_pc_i, exe_result_i;
  logic [A-1:0] exe_rfd_adr_i;
  logic         exe_rf_wb_i;
  logic [E-1:0] exe_except_i;
  logic         exe_bubble_i;
  logic [E-1:0] lsu_except_i;
  logic         pipeline_flush_i, du_stall_i;
  logic         ctrl_valid_o, ctrl_ready_i;
  logic [W-1:0] ctrl_pc_o, ctrl_result_o;
  logic [A-1:0] ctrl_rfd_adr_o;
  logic         ctrl_rf_wb_o;
  logic [E-1:0] ctrl_except_o;
  logic         ctrl_except_any_o;
  logic         wb_rf_wb_o;
  logic [A-1:0] wb_rfd_adr_o;
  logic [W-1:0] wb_result_o;
  logic [1:0]   count_o;

  exec_ctrl_queue #(
    .OPTION_OPERAND_WIDTH(W),
    .OPTION_RF_ADDR_WIDTH(A),
    .OPTION_RESET_PC(RST_PC),
    .NUM_EXCEPT(E),
    .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst),
    .exe_valid_i(exe_valid_i), .exe_ready_o(exe_ready_o),
    .exe_pc_i(exe_pc_i), .exe_result_i(exe_result_i),
    .exe_rfd_adr_i(exe_rfd_adr_i), .exe_rf_wb_i(exe_rf_wb_i),
    .exe_except_i(exe_except_i), .exe_bubble_i(exe_bubble_i),
    .lsu_except_i(lsu_except_i),
    .pipeline_flush_i(pipeline_flush_i), .du_stall_i(du_stall_i),
    .ctrl_valid_o(ctrl_valid_o), .ctrl_ready_i(ctrl_ready_i),
    .ctrl_pc_o(ctrl_pc_o), .ctrl_result_o(ctrl_result_o),
    .ctrl_rfd_adr_o(ctrl_rfd_adr_o), .ctrl_rf_wb_o(ctrl_rf_wb_o),
    .ctrl_except_o(ctrl_except_o), .ctrl_except_any_o(ctrl_except_any_o),
    .wb_rf_wb_o(wb_rf_wb_o), .wb_rfd_adr_o(wb_rfd_adr_o),
    .wb_result_o(wb_result_o), .count_o(count_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] pc;
    logic [W-1:0] res;
    logic [A-1:0] rd;
    logic         wb;
    logic [E-1:0] ex;
  } ent_t;

  ent_t         mq[$];
  logic [W-1:0] m_last_pc;
  logic         m_blk;
  logic         m_wbe;
  logic [A-1:0] m_wbd;
  logic [W-1:0] m_wbr;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle();
    rst = 1'b0; exe_valid_i = 1'b0; exe_pc_i = '0; exe_result_i = '0;
    exe_rfd_adr_i = '0; exe_rf_wb_i = 1'b0; exe_except_i = '0; exe_bubble_i = 1'b0;
    lsu_except_i = '0; pipeline_flush_i = 1'b0; du_stall_i = 1'b0; ctrl_ready_i = 1'b0;
  endtask

  task automatic set_push(input logic [W-1:0] pc, input logic [W-1:0] res,
                          input logic [A-1:0] rd, input logic wb, input logic bub);
    exe_valid_i = 1'b1; exe_pc_i = pc; exe_result_i = res;
    exe_rfd_adr_i = rd; exe_rf_wb_i = wb; exe_bubble_i = bub; exe_except_i = '0;
  endtask

  // Compare DUT against the model for the current inputs, then advance the model one edge.
  task automatic cycle();
    int cnt;
    logic flush_m, rdy, push_m, pop_m;
    logic [E-1:0] exp_ex;
    ent_t e;
    #1;
    cnt     = mq.size();
    flush_m = pipeline_flush_i && !du_stall_i;
    rdy     = (cnt != DEPTH) && !m_blk && !flush_m;
    exp_ex  = (cnt != 0) ? (mq[0].ex | lsu_except_i) : '0;
    chk("exe_ready", 64'(exe_ready_o), 64'(rdy));
    chk("ctrl_valid", 64'(ctrl_valid_o), 64'(cnt != 0));
    chk("count", 64'(count_o), 64'(cnt));
    chk("ctrl_except", 64'(ctrl_except_o), 64'(exp_ex));
    chk("ctrl_except_any", 64'(ctrl_except_any_o), 64'(exp_ex != 0));
    chk("ctrl_pc", 64'(ctrl_pc_o), 64'((cnt != 0) ? mq[0].pc : m_last_pc));
    chk("ctrl_rf_wb", 64'(ctrl_rf_wb_o), 64'((cnt != 0) ? mq[0].wb : 1'b0));
    if (cnt != 0) begin
      chk("ctrl_result", 64'(ctrl_result_o), 64'(mq[0].res));
      chk("ctrl_rfd_adr", 64'(ctrl_rfd_adr_o), 64'(mq[0].rd));
    end
    chk("wb_rf_wb", 64'(wb_rf_wb_o), 64'(m_wbe));
    chk("wb_rfd_adr", 64'(wb_rfd_adr_o), 64'(m_wbd));
    chk("wb_result", 64'(wb_result_o), 64'(m_wbr));

    if (rst) begin
      mq.delete(); m_last_pc = RST_PC; m_blk = 1'b0;
      m_wbe = 1'b0; m_wbd = '0; m_wbr = '0;
    end else if (flush_m) begin
      mq.delete(); m_blk = 1'b0; m_wbe = 1'b0;
    end else begin
      pop_m  = (cnt != 0) && ctrl_ready_i;
      push_m = exe_valid_i && rdy;
      if ((push_m && exe_except_i != 0) || (cnt != 0 && lsu_except_i != 0)) m_blk = 1'b1;
      if (pop_m) begin
        m_wbe = mq[0].wb && (exp_ex == 0);
        m_wbd = mq[0].rd;
        m_wbr = mq[0].res;
        void'(mq.pop_front());
      end else begin
        m_wbe = 1'b0;
        if (cnt != 0) mq[0].ex = exp_ex;
      end
      if (push_m) begin
        e.pc  = exe_bubble_i ? m_last_pc : exe_pc_i;
        e.res = exe_result_i;
        e.rd  = exe_rfd_adr_i;
        e.wb  = exe_rf_wb_i && !exe_bubble_i;
        e.ex  = exe_bubble_i ? '0 : exe_except_i;
        mq.push_back(e);
        if (!exe_bubble_i) m_last_pc = exe_pc_i;
      end
    end
    @(negedge clk);
    idle();
  endtask

  initial begin
    idle();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    m_last_pc = RST_PC; m_blk = 1'b0; m_wbe = 1'b0; m_wbd = '0; m_wbr = '0;
    rst = 1'b1;
    cycle();
    #1;
    chk("rst_count", 64'(count_o), 64'd0);
    chk("rst_ctrl_valid", 64'(ctrl_valid_o), 64'd0);
    chk("rst_ctrl_pc", 64'(ctrl_pc_o), 64'h100);
    chk("rst_exe_ready", 64'(exe_ready_o), 64'd1);

    // Single push then pop reaching writeback
    set_push(32'h200, 32'h55, 5'd3, 1'b1, 1'b0); ctrl_ready_i = 1'b1; cycle();
    #1; chk("lat_valid", 64'(ctrl_valid_o), 64'd1); chk("lat_pc", 64'(ctrl_pc_o), 64'h200);
    ctrl_ready_i = 1'b1; cycle();
    #1; chk("wb1_en", 64'(wb_rf_wb_o), 64'd1); chk("wb1_rd", 64'(wb_rfd_adr_o), 64'd3);
    chk("wb1_res", 64'(wb_result_o), 64'h55);

    // Fill, overflow attempt, ordered drain
    set_push(32'h210, 32'h1, 5'd1, 1'b1, 1'b0); cycle();
    set_push(32'h220, 32'h2, 5'd2, 1'b1, 1'b0); cycle();
    #1; chk("full_count", 64'(count_o), 64'd2); chk("full_ready", 64'(exe_ready_o), 64'd0);
    set_push(32'h230, 32'h3, 5'd4, 1'b1, 1'b0); cycle();
    #1; chk("ovf_count", 64'(count_o), 64'd2); chk("ovf_head", 64'(ctrl_pc_o), 64'h210);
    ctrl_ready_i = 1'b1; cycle();
    #1; chk("pop1_res", 64'(wb_result_o), 64'h1); chk("pop1_head", 64'(ctrl_pc_o), 64'h220);
    ctrl_ready_i = 1'b1; cycle();
    #1; chk("pop2_res", 64'(wb_result_o), 64'h2); chk("pop2_count", 64'(count_o), 64'd0);

    // Bubble inherits last real pc
    set_push(32'h300, 32'h30, 5'd5, 1'b1, 1'b0); cycle();
    set_push(32'h999, 32'h31, 5'd6, 1'b1, 1'b1); cycle();
    ctrl_ready_i = 1'b1; cycle();
    #1; chk("bub_pc", 64'(ctrl_pc_o), 64'h300); chk("bub_wb", 64'(ctrl_rf_wb_o), 64'd0);
    chk("bub_ex", 64'(ctrl_except_o), 64'd0);
    ctrl_ready_i = 1'b1; cycle();

    // Late exception sticks, blocks intake, kills writeback, cleared by flush
    set_push(32'h400, 32'h40, 5'd7, 1'b1, 1'b0); cycle();
    lsu_except_i = 11'h004; cycle();
    #1; chk("lsu_sticky", 64'(ctrl_except_o), 64'h4); chk("lsu_block", 64'(exe_ready_o), 64'd0);
    ctrl_ready_i = 1'b1; cycle();
    #1; chk("lsu_wb_kill", 64'(wb_rf_wb_o), 64'd0);
    pipeline_flush_i = 1'b1; cycle();
    #1; chk("flush_count", 64'(count_o), 64'd0); chk("flush_ready", 64'(exe_ready_o), 64'd1);

    // Flush masked by debug stall
    set_push(32'h500, 32'h50, 5'd8, 1'b1, 1'b0); cycle();
    set_push(32'h777, 32'h51, 5'd8, 1'b1, 1'b1); cycle();
    pipeline_flush_i = 1'b1; du_stall_i = 1'b1; cycle();
    #1; chk("stall_count", 64'(count_o), 64'd2);
    pipeline_flush_i = 1'b1; cycle();
    #1; chk("flush2_count", 64'(count_o), 64'd0); chk("flush2_pc", 64'(ctrl_pc_o), 64'h500);

    // Reset overriding push and pop with live writeback
    set_push(32'h600, 32'h66, 5'd9, 1'b1, 1'b0); cycle();
    set_push(32'h610, 32'h67, 5'd10, 1'b1, 1'b0); ctrl_ready_i = 1'b1; cycle();
    #1; chk("pre_rst_wb", 64'(wb_rf_wb_o), 64'd1); chk("pre_rst_count", 64'(count_o), 64'd1);
    set_push(32'h620, 32'h68, 5'd11, 1'b1, 1'b0); ctrl_ready_i = 1'b1; rst = 1'b1; cycle();
    #1; chk("rst2_count", 64'(count_o), 64'd0); chk("rst2_valid", 64'(ctrl_valid_o), 64'd0);
    chk("rst2_pc", 64'(ctrl_pc_o), 64'h100); chk("rst2_wb", 64'(wb_rf_wb_o), 64'd0);
    chk("rst2_rd", 64'(wb_rfd_adr_o), 64'd0); chk("rst2_res", 64'(wb_result_o), 64'd0);

    for (int i = 0; i < 4000; i++) begin
      rst              = ($urandom_range(199) == 0);
      exe_valid_i      = ($urandom_range(9) < 7);
      exe_pc_i         = $urandom;
      exe_result_i     = $urandom;
      exe_rfd_adr_i    = A'($urandom);
      exe_rf_wb_i      = $urandom_range(1);
      exe_bubble_i     = ($urandom_range(4) == 0);
      exe_except_i     = ($urandom_range(29) == 0) ? E'(1 << $urandom_range(E-1)) : '0;
      lsu_except_i     = ($urandom_range(24) == 0) ? E'(1 << $urandom_range(E-1)) : '0;
      pipeline_flush_i = ($urandom_range(19) == 0);
      du_stall_i       = ($urandom_range(3) == 0);
      ctrl_ready_i     = ($urandom_range(9) < 6);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
